// File: rtl/prefetch_if.sv
// Signal bundle between the prefetch unit, the instruction consumer and memory.
interface prefetch_if;
  logic [15:0] cs;
  logic [15:0] new_ip;
  logic        load_new_ip;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        mem_access;
  logic        mem_ack;
  logic [18:0] mem_address;
  logic [15:0] mem_data;
  logic [15:0] fetch_ip;

  // Environment view: the core steers fetching and pops bytes, memory answers reads.
  modport master (
    output cs, new_ip, load_new_ip, fifo_rd_en, mem_ack, mem_data,
    input  fifo_rd_data, fifo_empty, mem_access, mem_address, fetch_ip
  );

  // Prefetch unit view.
  modport slave (
    input  cs, new_ip, load_new_ip, fifo_rd_en, mem_ack, mem_data,
    output fifo_rd_data, fifo_empty, mem_access, mem_address, fetch_ip
  );
endinterface

// File: rtl/prefetch.sv
// Instruction prefetch unit: reads 16-bit words from cs:fetch_ip and feeds a
// byte FIFO that the decoder pops one byte at a time.
module prefetch #(
  parameter int FIFO_DEPTH = 6
) (
  input  logic      clk,
  input  logic      reset,
  prefetch_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE_HI,
    DISCARD
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      fetch_ip_q, fetch_ip_d;
  logic [18:0]      addr_q, addr_d;
  logic [7:0]       hi_byte_q, hi_byte_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];

  logic             push;
  logic [7:0]       push_byte;
  logic             pop;
  logic             room;
  logic [18:0]      word_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // (cs<<4) is always even, so the word address is (cs<<3) + (ip>>1) in 19 bits,
  // which gives the 1 MiB wrap for free.
  always_comb begin
    word_addr = {bus.cs, 3'b000} + {4'b0000, fetch_ip_q[15:1]};
    room      = fetch_ip_q[0] ? (count_q <= CNT_W'(FIFO_DEPTH - 1))
                              : (count_q <= CNT_W'(FIFO_DEPTH - 2));
    pop       = bus.fifo_rd_en && (count_q != '0) && !bus.load_new_ip;
  end

  // Fetch sequencer: request a word, split it into bytes, and drop any word
  // that was already in flight when the IP was redirected.
  always_comb begin
    state_d    = state_q;
    fetch_ip_d = fetch_ip_q;
    addr_d     = addr_q;
    hi_byte_d  = hi_byte_q;
    push       = 1'b0;
    push_byte  = 8'h00;

    case (state_q)
      IDLE: begin
        if (!bus.load_new_ip && room) begin
          addr_d  = word_addr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.load_new_ip) begin
          state_d = bus.mem_ack ? IDLE : DISCARD;
        end else if (bus.mem_ack) begin
          push       = 1'b1;
          fetch_ip_d = fetch_ip_q + 16'd1;
          if (fetch_ip_q[0]) begin
            push_byte = bus.mem_data[15:8];
            state_d   = IDLE;
          end else begin
            push_byte = bus.mem_data[7:0];
            hi_byte_d = bus.mem_data[15:8];
            state_d   = WRITE_HI;
          end
        end
      end
      WRITE_HI: begin
        if (!bus.load_new_ip) begin
          push       = 1'b1;
          push_byte  = hi_byte_q;
          fetch_ip_d = fetch_ip_q + 16'd1;
        end
        state_d = IDLE;
      end
      DISCARD: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.load_new_ip) begin
      fetch_ip_d = bus.new_ip;
      hi_byte_d  = 8'h00;
    end
  end

  // FIFO bookkeeping: a redirect empties it; otherwise push/pop move the pointers.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    if (bus.load_new_ip) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d  = ptr_inc(rd_ptr_q);
        rd_data_d = fifo_mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers; reset also drops a bus cycle in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_ip_q <= 16'h0000;
      addr_q     <= '0;
      hi_byte_q  <= 8'h00;
      rd_data_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_ip_q <= fetch_ip_d;
      addr_q     <= addr_d;
      hi_byte_q  <= hi_byte_d;
      rd_data_q  <= rd_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Byte storage needs no reset: the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_byte;
    end
  end

  assign bus.mem_access   = (state_q == FETCH) || (state_q == DISCARD);
  assign bus.mem_address  = addr_q;
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.fifo_rd_data = rd_data_q;
  assign bus.fetch_ip     = fetch_ip_q;

endmodule
